tile_fetch_arbiter: RTL and testbench
=====================================

// Module: tile_fetch_arbiter
// PURPOSE
//  Sequences maze tile-code reads from the shared map RAM so the combinational wall-sprite renderer
//  gets sprite_code/sx/sy for every pixel inside the maze window. Arbitrates the same single RAM
//  port between display prefetch (priority) and game-logic tile writes (pellet/wall updates).
//  Sits between the VGA timing generator and the sprite renderer.
// PARAMETERS
//  MAP_X0    208  first screen column of maze window
//  MAP_Y0    116  first screen row of maze window
//  MAP_COLS  28   tiles per row (8x8 px tiles)
//  MAP_ROWS  31   tile rows; MAP_COLS*MAP_ROWS <= 2**ADDR_W
//  ADDR_W    10   map RAM address width
//  COORD_W   10   pix_x/pix_y width
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        async active-low reset
//  pix_ce       in   1        pixel strobe; pulses >= 4 clk apart
//  pix_x        in   COORD_W  current pixel column (valid when pix_ce)
//  pix_y        in   COORD_W  current pixel row (valid when pix_ce)
//  wr_req       in   1        game-logic write request, held until wr_ack
//  wr_addr      in   ADDR_W   tile index row*MAP_COLS+col, stable while wr_req
//  wr_data      in   4        new sprite code
//  wr_ack       out  1        1-clk pulse, write performed/consumed
//  ram_addr     out  ADDR_W   map RAM address
//  ram_we       out  1        map RAM write enable
//  ram_wdata    out  4        map RAM write data
//  ram_rdata    in   4        map RAM read data, 1-clk synchronous read latency
//  sx           out  3        pixel column within tile
//  sy           out  3        pixel row within tile
//  sprite_code  out  4        tile code for current pixel; 0 outside maze
//  map_active   out  1        current pixel lies in maze window
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, fetch_pend=0, next_code=0. Reset mid-fetch/write aborts it;
//   held wr_req is re-arbitrated after release, no wr_ack for the aborted write.
//  In-map: MAP_X0<=x<MAP_X0+8*MAP_COLS and MAP_Y0<=y<MAP_Y0+8*MAP_ROWS; lx=x-MAP_X0, ly=y-MAP_Y0.
//  Pixel outputs (registered on pix_ce edge, held between strobes; 1-pixel latency, timing gen
//   delays syncs by one pixel externally):
//   in-map: sx=lx[2:0], sy=ly[2:0], map_active=1, sprite_code=(lx[2:0]==0)?next_code:hold.
//   outside: sx=sy=0, sprite_code=0, map_active=0.
//  Fetch trigger: pix_ce and y in-map and pixel x+1 in-map and (x+1-MAP_X0)[2:0]==0.
//   On trigger edge E0: fetch_addr<=(ly>>3)*MAP_COLS+((x+1-MAP_X0)>>3), fetch_pend<=1.
//   No trigger for last tile's successor (x+1 beyond window) nor rows outside window.
//  FSM states IDLE, FETCH, CAPTURE, WRITE:
//   IDLE: fetch_pend -> FETCH (clear pend); else wr_req and no trigger this cycle -> WRITE.
//   FETCH: ram_addr=fetch_addr, ram_we=0; -> CAPTURE.
//   CAPTURE: next_code<=ram_rdata; -> IDLE.
//   WRITE: ram_addr=wr_addr, ram_wdata=wr_data, ram_we=1 iff wr_addr<MAP_COLS*MAP_ROWS,
//    wr_ack=1 (out-of-range: acked, dropped); -> FETCH if fetch_pend else IDLE.
//  Timing guarantee: trigger at E0 -> FETCH by E1 -> next_code valid by E3, before next pix_ce (>=E4).
//  Write latency: <=4 clk from wr_req in IDLE; wr_req with trigger on same edge: fetch first,
//   write after CAPTURE; the fetch returns the pre-write value.
//  ram_we=0 and wr_ack=0 in every state except WRITE; ram_addr=0 in IDLE.
//  Address math unsigned, ADDR_W wide, no wrap (range guaranteed by parameter rule).
// TESTING
//  Reset: rst_n=0 mid-FETCH -> all outputs 0, ram_we=0; after release fetch resumes at next trigger.
//  RAM model mem[i]=i%16; pix_ce at (207,116) -> FETCH ram_addr=0; at (208,116) sprite_code=0,
//   sx=0, sy=0, map_active=1; at (216,116) sprite_code=1; at (207,124) fetch addr 28.
//  wr_req addr=29 data=5 while IDLE -> one cycle ram_we=1, ram_addr=29, ram_wdata=5, wr_ack=1
//   within 4 clk; later pixel (216,124) shows sprite_code=5.
//  wr_req asserted same edge as trigger -> FETCH, CAPTURE, then WRITE; wr_ack 3 clk after grant edge.
//  wr_addr=868 -> wr_ack=1, ram_we=0, mem unchanged.
//  Boundaries: (431,116) no fetch; (432,116) and (300,364) -> map_active=0, sprite_code=0;
//   frame wrap (0,0) -> outputs 0, no RAM access.

Source files
------------

// File: rtl/tile_fetch_arbiter.sv
// tile_fetch_arbiter
//   Fetches maze tile codes from the shared map RAM one tile ahead of the
//   beam, so the wall-sprite renderer always has sprite_code/sx/sy ready for
//   the pixel being drawn. The same single RAM port also carries game-logic
//   tile writes (pellet/wall updates). Display prefetch always wins over a
//   write.
//
// Ports
//   clk_i           system clock
//   rst_ni          asynchronous active-low reset
//   pix_ce_i        pixel strobe, at least 4 clocks apart
//   pix_x_i/pix_y_i current pixel coordinates, valid with pix_ce_i
//   wr_req_i        game-logic write request, held until wr_ack_o
//   wr_addr_i       tile index row*MAP_COLS+col
//   wr_data_i       new sprite code
//   wr_ack_o        one-clock pulse, write performed (or dropped if out of range)
//   ram_addr_o      map RAM address
//   ram_we_o        map RAM write enable
//   ram_wdata_o     map RAM write data
//   ram_rdata_i     map RAM read data, one clock synchronous latency
//   sx_o/sy_o       pixel position inside the current tile
//   sprite_code_o   tile code for the current pixel, 0 outside the maze
//   map_active_o    current pixel lies inside the maze window
module tile_fetch_arbiter #(
    parameter int unsigned MAP_X0   = 208,
    parameter int unsigned MAP_Y0   = 116,
    parameter int unsigned MAP_COLS = 28,
    parameter int unsigned MAP_ROWS = 31,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned COORD_W  = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               pix_ce_i,
    input  logic [COORD_W-1:0] pix_x_i,
    input  logic [COORD_W-1:0] pix_y_i,
    input  logic               wr_req_i,
    input  logic [ADDR_W-1:0]  wr_addr_i,
    input  logic [3:0]         wr_data_i,
    output logic               wr_ack_o,
    output logic [ADDR_W-1:0]  ram_addr_o,
    output logic               ram_we_o,
    output logic [3:0]         ram_wdata_o,
    input  logic [3:0]         ram_rdata_i,
    output logic [2:0]         sx_o,
    output logic [2:0]         sy_o,
    output logic [3:0]         sprite_code_o,
    output logic               map_active_o
);

    // One extra bit so x+1 and the window upper bounds never overflow.
    localparam int unsigned CW = COORD_W + 1;
    localparam logic [CW-1:0] X_LO = CW'(MAP_X0);
    localparam logic [CW-1:0] X_HI = CW'(MAP_X0 + 8 * MAP_COLS);
    localparam logic [CW-1:0] Y_LO = CW'(MAP_Y0);
    localparam logic [CW-1:0] Y_HI = CW'(MAP_Y0 + 8 * MAP_ROWS);
    localparam logic [ADDR_W:0] TILE_COUNT = (ADDR_W + 1)'(MAP_COLS * MAP_ROWS);

    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, WRITE} state_e;

    state_e             state_q;
    logic               fetchPend_q;
    logic [ADDR_W-1:0]  fetchAddr_q;
    logic [3:0]         nextCode_q;
    logic [ADDR_W-1:0]  ramAddr_q;
    logic               ramWe_q;
    logic [3:0]         ramWdata_q;
    logic               wrAck_q;

    logic [2:0]         sx_q, sx_d;
    logic [2:0]         sy_q, sy_d;
    logic [3:0]         code_q, code_d;
    logic               active_q, active_d;

    logic [CW-1:0]      xExt, yExt, xNext, ly, lxNext;
    logic [2:0]         lxLow;
    logic               xIn, yIn, xNextIn, inMap, trigger, wrInRange;
    logic [ADDR_W-1:0]  fetchAddrCalc;

    // Window decode and fetch trigger. The fetch for a tile is launched on
    // the pixel just before it, so the code is ready when the beam arrives.
    // The local offsets are only meaningful when the matching in-window
    // flag is set.
    always_comb begin
        xExt          = {1'b0, pix_x_i};
        yExt          = {1'b0, pix_y_i};
        xNext         = xExt + CW'(1);
        ly            = yExt - Y_LO;
        lxNext        = xNext - X_LO;
        lxLow         = 3'(xExt - X_LO);
        xIn           = (xExt >= X_LO) && (xExt < X_HI);
        yIn           = (yExt >= Y_LO) && (yExt < Y_HI);
        xNextIn       = (xNext >= X_LO) && (xNext < X_HI);
        inMap         = xIn && yIn;
        trigger       = pix_ce_i && yIn && xNextIn && (lxNext[2:0] == 3'd0);
        fetchAddrCalc = ADDR_W'(ly >> 3) * ADDR_W'(MAP_COLS) + ADDR_W'(lxNext >> 3);
        wrInRange     = {1'b0, wr_addr_i} < TILE_COUNT;
    end

    // Pixel outputs change only on a pixel strobe. The sprite code switches
    // to the prefetched value at the first column of each tile and is held
    // for the remaining seven columns.
    always_comb begin
        sx_d     = sx_q;
        sy_d     = sy_q;
        code_d   = code_q;
        active_d = active_q;
        if (pix_ce_i) begin
            if (inMap) begin
                sx_d     = lxLow;
                sy_d     = ly[2:0];
                active_d = 1'b1;
                if (lxLow == 3'd0) begin
                    code_d = nextCode_q;
                end
            end else begin
                sx_d     = 3'd0;
                sy_d     = 3'd0;
                code_d   = 4'd0;
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sx_q     <= 3'd0;
            sy_q     <= 3'd0;
            code_q   <= 4'd0;
            active_q <= 1'b0;
        end else begin
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            code_q   <= code_d;
            active_q <= active_d;
        end
    end

    // RAM port arbiter. The RAM-side outputs are registered together with the
    // state they belong to, so they are valid for the whole cycle spent in
    // that state. A write is never granted on the edge that raises a fetch,
    // which keeps the fetch's E0..E3 schedule intact.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            fetchPend_q <= 1'b0;
            fetchAddr_q <= '0;
            nextCode_q  <= 4'd0;
            ramAddr_q   <= '0;
            ramWe_q     <= 1'b0;
            ramWdata_q  <= 4'd0;
            wrAck_q     <= 1'b0;
        end else begin
            ramWe_q    <= 1'b0;
            ramWdata_q <= 4'd0;
            wrAck_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fetchPend_q) begin
                        state_q     <= FETCH;
                        fetchPend_q <= 1'b0;
                        ramAddr_q   <= fetchAddr_q;
                    end else if (wr_req_i && !trigger) begin
                        state_q    <= WRITE;
                        ramAddr_q  <= wr_addr_i;
                        ramWdata_q <= wr_data_i;
                        ramWe_q    <= wrInRange;
                        wrAck_q    <= 1'b1;
                    end else begin
                        ramAddr_q <= '0;
                    end
                end
                FETCH: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    nextCode_q <= ram_rdata_i;
                    state_q    <= IDLE;
                    ramAddr_q  <= '0;
                end
                WRITE: begin
                    if (fetchPend_q) begin
                        state_q     <= FETCH;
                        fetchPend_q <= 1'b0;
                        ramAddr_q   <= fetchAddr_q;
                    end else begin
                        state_q   <= IDLE;
                        ramAddr_q <= '0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    ramAddr_q <= '0;
                end
            endcase
            // A new trigger takes precedence over the pending-flag clear above.
            if (trigger) begin
                fetchPend_q <= 1'b1;
                fetchAddr_q <= fetchAddrCalc;
            end
        end
    end

    assign wr_ack_o      = wrAck_q;
    assign ram_addr_o    = ramAddr_q;
    assign ram_we_o      = ramWe_q;
    assign ram_wdata_o   = ramWdata_q;
    assign sx_o          = sx_q;
    assign sy_o          = sy_q;
    assign sprite_code_o = code_q;
    assign map_active_o  = active_q;

endmodule

// File: tb/tb_tile_fetch_arbiter.sv
// tb_tile_fetch_arbiter
//   Self-checking bench for tile_fetch_arbiter. A behavioural map RAM
//   (mem[i] = i % 16, one clock read latency) sits on the RAM port. Expected
//   pixel outputs and expected write transactions are queued when stimulus
//   is driven and compared when the DUT produces them.
module tb_tile_fetch_arbiter;

    localparam int X0   = 208;
    localparam int Y0   = 116;
    localparam int COLS = 28;
    localparam int ROWS = 31;

    typedef struct packed {
        logic [2:0] sx;
        logic [2:0] sy;
        logic [3:0] code;
        logic       active;
    } pixExp_t;

    typedef struct packed {
        logic [9:0] addr;
        logic [3:0] data;
        logic       we;
    } wrExp_t;

    logic       clk = 1'b0;
    logic       rstN;
    logic       pixCe;
    logic [9:0] pixX;
    logic [9:0] pixY;
    logic       wrReq;
    logic [9:0] wrAddr;
    logic [3:0] wrData;
    logic       wrAck;
    logic [9:0] ramAddr;
    logic       ramWe;
    logic [3:0] ramWdata;
    logic [3:0] ramRdata;
    logic [2:0] sx;
    logic [2:0] sy;
    logic [3:0] spriteCode;
    logic       mapActive;

    logic [3:0] ramMem [0:1023];
    bit         memLoaded = 1'b0;

    logic [3:0] modelMem [0:1023];
    logic [3:0] modelNext;
    logic [3:0] modelCode;

    pixExp_t    pixQ [$];
    wrExp_t     wrQ [$];

    int         checkCount = 0;
    int         passCount  = 0;

    tile_fetch_arbiter dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .pix_ce_i      (pixCe),
        .pix_x_i       (pixX),
        .pix_y_i       (pixY),
        .wr_req_i      (wrReq),
        .wr_addr_i     (wrAddr),
        .wr_data_i     (wrData),
        .wr_ack_o      (wrAck),
        .ram_addr_o    (ramAddr),
        .ram_we_o      (ramWe),
        .ram_wdata_o   (ramWdata),
        .ram_rdata_i   (ramRdata),
        .sx_o          (sx),
        .sy_o          (sy),
        .sprite_code_o (spriteCode),
        .map_active_o  (mapActive)
    );

    always #5 clk = ~clk;

    // Map RAM: contents are loaded on the first clock (during reset),
    // then behaves as a single-port RAM with registered read data.
    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < 1024; i++) begin
                ramMem[i] <= 4'(i % 16);
            end
            memLoaded <= 1'b1;
        end else if (ramWe) begin
            ramMem[ramAddr] <= ramWdata;
        end
        ramRdata <= ramMem[ramAddr];
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives one pixel strobe (entered and left on a falling clock edge,
    // four clocks per pixel). The tile-ahead fetch is predicted from the
    // expectation memory at strobe time, which gives the pre-write value
    // when a write is requested on the same edge.
    task automatic applyStimulus(input int x, input int y);
        pixExp_t e;
        bit      trig;
        int      addr;
        int      lx;
        int      ly;
        int      nx;
        pixX  = 10'(x);
        pixY  = 10'(y);
        pixCe = 1'b1;
        trig  = 1'b0;
        addr  = 0;
        if (x >= X0 && x < X0 + 8 * COLS && y >= Y0 && y < Y0 + 8 * ROWS) begin
            lx = x - X0;
            ly = y - Y0;
            if (lx % 8 == 0) modelCode = modelNext;
            e.sx     = 3'(lx % 8);
            e.sy     = 3'(ly % 8);
            e.code   = modelCode;
            e.active = 1'b1;
        end else begin
            modelCode = 4'd0;
            e         = '0;
        end
        nx = x + 1;
        if (y >= Y0 && y < Y0 + 8 * ROWS && nx >= X0 && nx < X0 + 8 * COLS && (nx - X0) % 8 == 0) begin
            trig      = 1'b1;
            addr      = ((y - Y0) / 8) * COLS + (nx - X0) / 8;
            modelNext = modelMem[addr];
        end
        pixQ.push_back(e);
        @(negedge clk);
        pixCe = 1'b0;
        e = pixQ.pop_front();
        checkOutput($sformatf("sx(%0d,%0d)", x, y), int'(sx), int'(e.sx));
        checkOutput($sformatf("sy(%0d,%0d)", x, y), int'(sy), int'(e.sy));
        checkOutput($sformatf("code(%0d,%0d)", x, y), int'(spriteCode), int'(e.code));
        checkOutput($sformatf("active(%0d,%0d)", x, y), int'(mapActive), int'(e.active));
        @(negedge clk);
        if (trig) begin
            checkOutput($sformatf("fetchAddr(%0d,%0d)", x, y), int'(ramAddr), addr);
            checkOutput($sformatf("fetchWe(%0d,%0d)", x, y), int'(ramWe), 0);
        end else begin
            checkOutput($sformatf("idleAddr(%0d,%0d)", x, y), int'(ramAddr), 0);
            checkOutput($sformatf("idleWe(%0d,%0d)", x, y), int'(ramWe), 0);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    // Raises a write request on a falling edge and waits (bounded) for the
    // acknowledge. expEdges is the number of rising edges until wr_ack is
    // visible, counting the edge right after the request is raised.
    task automatic requestWrite(input int addr, input int data, input int expEdges);
        wrExp_t e;
        int     edges;
        bit     acked;
        e.addr = 10'(addr);
        e.data = 4'(data);
        e.we   = (addr < COLS * ROWS);
        wrQ.push_back(e);
        wrAddr = 10'(addr);
        wrData = 4'(data);
        wrReq  = 1'b1;
        edges  = 0;
        acked  = 1'b0;
        while (!acked && edges < 12) begin
            @(negedge clk);
            edges++;
            if (wrAck) acked = 1'b1;
        end
        wrReq = 1'b0;
        checkOutput($sformatf("wrAckSeen(%0d)", addr), int'(acked), 1);
        checkOutput($sformatf("wrLatency(%0d)", addr), edges, expEdges);
        if (acked) begin
            e = wrQ.pop_front();
            checkOutput($sformatf("wrRamAddr(%0d)", addr), int'(ramAddr), int'(e.addr));
            checkOutput($sformatf("wrRamData(%0d)", addr), int'(ramWdata), int'(e.data));
            checkOutput($sformatf("wrRamWe(%0d)", addr), int'(ramWe), int'(e.we));
            @(negedge clk);
            checkOutput($sformatf("wrAckPulse(%0d)", addr), int'(wrAck), 0);
            checkOutput($sformatf("wrWeOff(%0d)", addr), int'(ramWe), 0);
            if (e.we) modelMem[addr] = 4'(data);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".sx"}, int'(sx), 0);
        checkOutput({tag, ".sy"}, int'(sy), 0);
        checkOutput({tag, ".code"}, int'(spriteCode), 0);
        checkOutput({tag, ".active"}, int'(mapActive), 0);
        checkOutput({tag, ".ramAddr"}, int'(ramAddr), 0);
        checkOutput({tag, ".ramWe"}, int'(ramWe), 0);
        checkOutput({tag, ".ramWdata"}, int'(ramWdata), 0);
        checkOutput({tag, ".wrAck"}, int'(wrAck), 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) modelMem[i] = 4'(i % 16);
        modelNext = 4'd0;
        modelCode = 4'd0;
        rstN   = 1'b0;
        pixCe  = 1'b0;
        pixX   = '0;
        pixY   = '0;
        wrReq  = 1'b0;
        wrAddr = '0;
        wrData = '0;

        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rstN = 1'b1;
        @(negedge clk);

        $display("[TB] first row fetches");
        applyStimulus(207, 116);
        applyStimulus(208, 116);
        applyStimulus(215, 116);
        applyStimulus(216, 116);
        applyStimulus(207, 124);
        applyStimulus(208, 124);

        $display("[TB] write while idle");
        requestWrite(29, 5, 1);
        applyStimulus(215, 124);
        applyStimulus(216, 124);
        applyStimulus(217, 124);

        $display("[TB] write on the same edge as a fetch trigger");
        fork
            applyStimulus(223, 124);
            requestWrite(30, 9, 5);
        join
        applyStimulus(224, 124);
        applyStimulus(223, 125);
        applyStimulus(224, 125);

        $display("[TB] out-of-range write");
        requestWrite(868, 7, 1);
        checkOutput("oorMemUnchanged", int'(ramMem[868]), 4);

        $display("[TB] window boundaries");
        applyStimulus(430, 116);
        applyStimulus(431, 116);
        applyStimulus(432, 116);
        applyStimulus(300, 363);
        applyStimulus(300, 364);
        applyStimulus(0, 0);

        $display("[TB] reset during a fetch");
        pixX  = 10'd215;
        pixY  = 10'd116;
        pixCe = 1'b1;
        @(negedge clk);
        pixCe = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midFetchAddr", int'(ramAddr), 1);
        rstN = 1'b0;
        #1;
        checkAllZero("midFetchReset");
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        modelNext = 4'd0;
        modelCode = 4'd0;
        @(negedge clk);
        applyStimulus(216, 116);
        applyStimulus(223, 116);
        applyStimulus(224, 116);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
